lfo_scheduler: RTL and testbench

LFO_SCHEDULER -- requirements
Module: lfo_scheduler

---
 rtl/lfo_pkg.sv | 21 ++
 rtl/lfo_wave_shaper.sv | 35 +++
 rtl/lfo_scheduler.sv | 134 +++++++++++++
 tb/tb_lfo_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfo_pkg.sv
// Shared types and default sizing for the LFO scheduler and its wave shaper.
package lfo_pkg;

  localparam int unsigned NUM_CH_DEF  = 4;
  localparam int unsigned PHASE_W_DEF = 32;
  localparam int unsigned OUT_W_DEF   = 16;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StEmit
  } state_e;

  typedef enum logic [1:0] {
    SAW     = 2'd0,
    SQUARE  = 2'd1,
    TRI     = 2'd2,
    RAMP_DN = 2'd3
  } wave_e;

endpackage

// File: rtl/lfo_wave_shaper.sv
// Combinational mapping from an updated phase value to an output sample.
module lfo_wave_shaper
  import lfo_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF
) (
  input  logic [PHASE_W-1:0] phase,
  input  wave_e              wave,
  output logic [OUT_W-1:0]   sample
);

  // Top OUT_W+1 phase bits; the extra MSB selects the half-period.
  logic [OUT_W:0] p;
  assign p = phase[PHASE_W-1 -: OUT_W+1];

  generate
    if (PHASE_W > OUT_W + 1) begin : g_low_bits
      logic unused_low;
      assign unused_low = ^phase[PHASE_W-OUT_W-2:0];
    end
  endgenerate

  always_comb begin
    sample = '0;
    case (wave)
      SAW:     sample = p[OUT_W:1];
      SQUARE:  sample = {OUT_W{p[OUT_W]}};
      TRI:     sample = p[OUT_W] ? ~p[OUT_W-1:0] : p[OUT_W-1:0];
      RAMP_DN: sample = ~p[OUT_W:1];
      default: sample = '0;
    endcase
  end

endmodule

// File: rtl/lfo_scheduler.sv
// Multi-channel LFO: one shared phase adder swept over all channels per tick,
// each sample handed out over a valid/ready port.
module lfo_scheduler
  import lfo_pkg::*;
#(
  parameter int unsigned NUM_CH  = NUM_CH_DEF,
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               tick,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [PHASE_W-1:0] cfg_incr,
  input  logic [1:0]         cfg_wave,
  input  logic               cfg_en,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH_W-1:0]    out_ch,
  output logic [OUT_W-1:0]   out_data,
  output logic               overrun
);

  state_e              state_q;
  logic [CH_W-1:0]     ch_q;
  logic [PHASE_W-1:0]  phase_q    [NUM_CH];
  logic [PHASE_W-1:0]  incr_sh_q  [NUM_CH];
  logic [PHASE_W-1:0]  incr_act_q [NUM_CH];
  wave_e               wave_sh_q  [NUM_CH];
  wave_e               wave_act_q [NUM_CH];
  logic [NUM_CH-1:0]   en_sh_q;
  logic [NUM_CH-1:0]   en_act_q;

  logic                cfg_hit;
  logic                last_ch;
  logic [PHASE_W-1:0]  phase_sum;
  logic [PHASE_W-1:0]  phase_nxt;
  logic [OUT_W-1:0]    sample;

  assign cfg_hit = cfg_we && (32'(cfg_ch) < NUM_CH);
  assign last_ch = (ch_q == CH_W'(NUM_CH - 1));

  // Single adder shared by all channels; wrap-around is silent.
  assign phase_sum = phase_q[ch_q] + incr_act_q[ch_q];
  assign phase_nxt = en_act_q[ch_q] ? phase_sum : '0;

  lfo_wave_shaper #(
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W)
  ) u_shaper (
    .phase  (phase_nxt),
    .wave   (wave_act_q[ch_q]),
    .sample (sample)
  );

  // Shadow configuration: writable at any time, only sampled at sweep start.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        incr_sh_q[i] <= '0;
        wave_sh_q[i] <= SAW;
      end
      en_sh_q <= '0;
    end else if (cfg_hit) begin
      incr_sh_q[cfg_ch] <= cfg_incr;
      wave_sh_q[cfg_ch] <= wave_e'(cfg_wave);
      en_sh_q[cfg_ch]   <= cfg_en;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        phase_q[i]    <= '0;
        incr_act_q[i] <= '0;
        wave_act_q[i] <= SAW;
      end
      en_act_q  <= '0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= tick && (state_q != StIdle);
      case (state_q)
        StIdle: begin
          if (tick) begin
            for (int i = 0; i < NUM_CH; i++) begin
              incr_act_q[i] <= incr_sh_q[i];
              wave_act_q[i] <= wave_sh_q[i];
            end
            en_act_q <= en_sh_q;
            // A write landing on the accepting cycle goes straight to the active copy.
            if (cfg_hit) begin
              incr_act_q[cfg_ch] <= cfg_incr;
              wave_act_q[cfg_ch] <= wave_e'(cfg_wave);
              en_act_q[cfg_ch]   <= cfg_en;
            end
            ch_q    <= '0;
            busy    <= 1'b1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          phase_q[ch_q] <= phase_nxt;
          out_data      <= en_act_q[ch_q] ? sample : '0;
          out_ch        <= ch_q;
          out_valid     <= 1'b1;
          state_q       <= StEmit;
        end
        StEmit: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_ch) begin
              busy    <= 1'b0;
              state_q <= StIdle;
            end else begin
              ch_q    <= ch_q + CH_W'(1);
              state_q <= StCalc;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lfo_scheduler.sv
// Scoreboard bench for lfo_scheduler: directed sweeps with hand-computed samples.
module tb_lfo_scheduler;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned PHASE_W = 32;
  localparam int unsigned OUT_W   = 16;

  logic               ACLK = 1'b0;
  logic               ARESETN = 1'b0;
  logic               tick = 1'b0;
  logic               cfg_we = 1'b0;
  logic [1:0]         cfg_ch = '0;
  logic [PHASE_W-1:0] cfg_incr = '0;
  logic [1:0]         cfg_wave = '0;
  logic               cfg_en = 1'b0;
  logic               busy;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [1:0]         out_ch;
  logic [OUT_W-1:0]   out_data;
  logic               overrun;

  lfo_scheduler #(
    .NUM_CH  (NUM_CH),
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W)
  ) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .tick      (tick),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_incr  (cfg_incr),
    .cfg_wave  (cfg_wave),
    .cfg_en    (cfg_en),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .overrun   (overrun)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   pops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted sample must match the head of the scoreboard.
  always @(negedge ACLK) begin
    if (ARESETN && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected sample: got ch=%0d data=0x%0h, expected none", out_ch, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        pops++;
        check($sformatf("sample ch%0d", mon_e.ch), {14'b0, out_ch, out_data},
              {14'b0, mon_e.ch, mon_e.data});
      end
    end
  end

  task automatic cycle();
    @(posedge ACLK);
    #1;
  endtask

  task automatic cfg(input int c, input logic [31:0] inc, input logic [1:0] w, input logic e);
    cfg_we   = 1'b1;
    cfg_ch   = c[1:0];
    cfg_incr = inc;
    cfg_wave = w;
    cfg_en   = e;
    cycle();
    cfg_we   = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  task automatic push4(input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3);
    exp_q.push_back('{ch: 2'd0, data: d0});
    exp_q.push_back('{ch: 2'd1, data: d1});
    exp_q.push_back('{ch: 2'd2, data: d2});
    exp_q.push_back('{ch: 2'd3, data: d3});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      cycle();
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL %s timeout: busy still 1, expected 0 within 100 cycles", name);
    end
    check({name, " drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int ovr;
    int p0;

    // Reset state
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_ch", 32'(out_ch), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    cycle();
    ARESETN = 1'b1;
    cycle();

    // Saw on ch0, square on ch1, others disabled (emit 0)
    cfg(0, 32'h0100_0000, 2'd0, 1'b1);
    cfg(1, 32'h8000_0000, 2'd1, 1'b1);
    push4(16'h0100, 16'hFFFF, 16'h0000, 16'h0000);
    do_tick();
    check("busy after tick", 32'(busy), 32'd1);
    wait_idle("sweep1");
    push4(16'h0200, 16'h0000, 16'h0000, 16'h0000);
    do_tick();
    wait_idle("sweep2");
    push4(16'h0300, 16'hFFFF, 16'h0000, 16'h0000);
    do_tick();
    wait_idle("sweep3");

    // Back-pressure on ch0
    out_ready = 1'b0;
    push4(16'h0400, 16'h0000, 16'h0000, 16'h0000);
    do_tick();
    n = 0;
    while (!out_valid && n < 10) begin
      cycle();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall out_valid", 32'(out_valid), 32'd1);
      check("stall out_data", 32'(out_data), 32'h0400);
      check("stall out_ch", 32'(out_ch), 32'd0);
      check("stall busy", 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    wait_idle("sweep4");

    // Tick dropped mid-sweep
    push4(16'h0500, 16'hFFFF, 16'h0000, 16'h0000);
    p0 = pops;
    do_tick();
    cycle();
    cycle();
    tick = 1'b1;
    ovr = 0;
    n = 0;
    do begin
      cycle();
      tick = 1'b0;
      if (overrun) ovr++;
      n++;
    end while (busy && n < 100);
    check("overrun pulse cycles", 32'(ovr), 32'd1);
    check("overrun sweep samples", 32'(pops - p0), 32'd4);
    check("overrun sweep busy", 32'(busy), 32'd0);
    check("overrun sweep drained", 32'(exp_q.size()), 32'd0);

    // ch2 triangle, reconfigured mid-sweep
    cfg(2, 32'h1000_0000, 2'd2, 1'b1);
    push4(16'h0600, 16'h0000, 16'h2000, 16'h0000);
    do_tick();
    wait_idle("sweep6");
    push4(16'h0700, 16'hFFFF, 16'h4000, 16'h0000);
    do_tick();
    cfg(2, 32'h7000_0000, 2'd2, 1'b1);
    wait_idle("sweep7");
    push4(16'h0800, 16'h0000, 16'hDFFF, 16'h0000);
    do_tick();
    wait_idle("sweep8");

    // Write coinciding with the accepted tick; ch2 wraps to 0
    push4(16'h0900, 16'hFFFF, 16'h0000, 16'hBFFF);
    cfg_we   = 1'b1;
    cfg_ch   = 2'd3;
    cfg_incr = 32'h4000_0000;
    cfg_wave = 2'd3;
    cfg_en   = 1'b1;
    tick     = 1'b1;
    cycle();
    cfg_we   = 1'b0;
    tick     = 1'b0;
    wait_idle("sweep9");

    // Reset during ch1 EMIT
    exp_q.push_back('{ch: 2'd0, data: 16'h0A00});
    do_tick();
    n = 0;
    while (!(out_valid && out_ch == 2'd1) && n < 20) begin
      cycle();
      n++;
    end
    out_ready = 1'b0;
    check("ch1 emit reached", 32'(out_valid && out_ch == 2'd1), 32'd1);
    @(negedge ACLK);
    ARESETN = 1'b0;
    #1;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset out_data", 32'(out_data), 32'd0);
    check("mid reset out_ch", 32'(out_ch), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    cycle();
    ARESETN = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("post reset no valid", 32'(out_valid), 32'd0);
    end
    check("reset sweep drained", 32'(exp_q.size()), 32'd0);
    cfg(0, 32'h0100_0000, 2'd0, 1'b1);
    push4(16'h0100, 16'h0000, 16'h0000, 16'h0000);
    do_tick();
    wait_idle("sweep after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
